// File: rtl/led_scan_controller_if.sv
// Display register side of the LED scan controller: digit data and control in,
// pad-level segment/cathode drive and frame status out.
interface led_scan_controller_if #(
   parameter int unsigned NUM_DIGITS = 4
);
   logic                      load;
   logic [4*NUM_DIGITS-1:0]   value;
   logic [NUM_DIGITS-1:0]     dp_mask;
   logic [NUM_DIGITS-1:0]     blank_mask;
   logic                      enable;
   logic                      seg_a;
   logic                      seg_b;
   logic                      seg_c;
   logic                      seg_d;
   logic                      seg_e;
   logic                      seg_f;
   logic                      seg_g;
   logic                      dp;
   logic [NUM_DIGITS-1:0]     n_digit;
   logic                      frame_tick;
   logic                      pending;

   modport master (
      output load, value, dp_mask, blank_mask, enable,
      input  seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g, dp, n_digit, frame_tick, pending
   );

   modport slave (
      input  load, value, dp_mask, blank_mask, enable,
      output seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g, dp, n_digit, frame_tick, pending
   );
endinterface

// File: rtl/led_scan_controller.sv
// Multiplexed 7-segment scan sequencer with frame-synchronous double buffering
// and a blanking gap between digits.
module led_scan_controller #(
   parameter int unsigned NUM_DIGITS   = 4,
   parameter int unsigned DIGIT_CYCLES = 8,
   parameter int unsigned BLANK_CYCLES = 1
) (
   input logic                  clk,
   input logic                  rst,
   led_scan_controller_if.slave bus
);
   localparam int unsigned IdxW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int unsigned MaxCyc = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
   localparam int unsigned CntW   = (MaxCyc > 1) ? $clog2(MaxCyc) : 1;

   localparam logic [IdxW-1:0] IdxLast = IdxW'(NUM_DIGITS - 1);
   localparam logic [CntW-1:0] DigLast = CntW'(DIGIT_CYCLES - 1);
   localparam logic [CntW-1:0] BlkLast = CntW'(BLANK_CYCLES - 1);

   typedef enum logic {StBlank, StDrive} state_e;

   state_e                  state_q;
   logic [CntW-1:0]         cnt_q;
   logic [IdxW-1:0]         idx_q;
   logic                    off_q;
   logic [4*NUM_DIGITS-1:0] act_value_q, pend_value_q;
   logic [NUM_DIGITS-1:0]   act_dp_q, pend_dp_q;
   logic [NUM_DIGITS-1:0]   act_blank_q, pend_blank_q;
   logic                    pend_q;
   logic                    tick_q;
   logic [6:0]              seg_q;
   logic                    dp_q;
   logic [NUM_DIGITS-1:0]   n_digit_q;

   logic [3:0] nib;
   logic       cur_dp;
   logic       cur_blank;
   logic       boundary;

   function automatic logic [6:0] decode(input logic [3:0] h);
      // bit order {g,f,e,d,c,b,a}
      case (h)
         4'h0: decode = 7'h3F;
         4'h1: decode = 7'h06;
         4'h2: decode = 7'h5B;
         4'h3: decode = 7'h4F;
         4'h4: decode = 7'h66;
         4'h5: decode = 7'h6D;
         4'h6: decode = 7'h7D;
         4'h7: decode = 7'h07;
         4'h8: decode = 7'h7F;
         4'h9: decode = 7'h6F;
         4'hA: decode = 7'h77;
         4'hB: decode = 7'h7C;
         4'hC: decode = 7'h39;
         4'hD: decode = 7'h5E;
         4'hE: decode = 7'h79;
         default: decode = 7'h71;
      endcase
   endfunction

   always_comb begin
      nib       = 4'h0;
      cur_dp    = 1'b0;
      cur_blank = 1'b1;
      for (int i = 0; i < int'(NUM_DIGITS); i++) begin
         if (idx_q == IdxW'(i)) begin
            nib       = act_value_q[4*i +: 4];
            cur_dp    = act_dp_q[i];
            cur_blank = act_blank_q[i];
         end
      end
   end

   assign boundary = bus.enable && (state_q == StDrive) && (idx_q == IdxLast) &&
                     (cnt_q == DigLast);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StBlank;
         cnt_q        <= '0;
         idx_q        <= '0;
         off_q        <= 1'b0;
         act_value_q  <= '0;
         act_dp_q     <= '0;
         act_blank_q  <= '1;
         pend_value_q <= '0;
         pend_dp_q    <= '0;
         pend_blank_q <= '1;
         pend_q       <= 1'b0;
         tick_q       <= 1'b0;
         seg_q        <= '0;
         dp_q         <= 1'b0;
         n_digit_q    <= '1;
      end else begin
         tick_q <= 1'b0;
         if (boundary) begin
            // A load in the boundary cycle goes straight to the active buffer.
            if (bus.load) begin
               act_value_q <= bus.value;
               act_dp_q    <= bus.dp_mask;
               act_blank_q <= bus.blank_mask;
            end else if (pend_q) begin
               act_value_q <= pend_value_q;
               act_dp_q    <= pend_dp_q;
               act_blank_q <= pend_blank_q;
            end
            pend_q <= 1'b0;
            tick_q <= 1'b1;
         end else if (bus.load) begin
            pend_value_q <= bus.value;
            pend_dp_q    <= bus.dp_mask;
            pend_blank_q <= bus.blank_mask;
            pend_q       <= 1'b1;
         end

         if (!bus.enable) begin
            state_q   <= StBlank;
            cnt_q     <= '0;
            off_q     <= 1'b1;
            seg_q     <= '0;
            dp_q      <= 1'b0;
            n_digit_q <= '1;
         end else if (off_q) begin
            // Resume edge: the blank phase starts fresh from here.
            off_q <= 1'b0;
         end else if (state_q == StBlank) begin
            if (cnt_q == BlkLast) begin
               state_q   <= StDrive;
               cnt_q     <= '0;
               seg_q     <= cur_blank ? 7'h00 : decode(nib);
               dp_q      <= !cur_blank && cur_dp;
               n_digit_q <= cur_blank ? '1 : ~(NUM_DIGITS'(1) << idx_q);
            end else begin
               cnt_q <= cnt_q + CntW'(1);
            end
         end else begin
            if (cnt_q == DigLast) begin
               state_q   <= StBlank;
               cnt_q     <= '0;
               idx_q     <= (idx_q == IdxLast) ? '0 : idx_q + IdxW'(1);
               seg_q     <= '0;
               dp_q      <= 1'b0;
               n_digit_q <= '1;
            end else begin
               cnt_q <= cnt_q + CntW'(1);
            end
         end
      end
   end

   assign bus.seg_a      = seg_q[0];
   assign bus.seg_b      = seg_q[1];
   assign bus.seg_c      = seg_q[2];
   assign bus.seg_d      = seg_q[3];
   assign bus.seg_e      = seg_q[4];
   assign bus.seg_f      = seg_q[5];
   assign bus.seg_g      = seg_q[6];
   assign bus.dp         = dp_q;
   assign bus.n_digit    = n_digit_q;
   assign bus.frame_tick = tick_q;
   assign bus.pending    = pend_q;
endmodule

// File: tb/tb_led_scan_controller.sv
// Directed bench for led_scan_controller: per-frame capture of what each digit
// showed, plus continuous checks on cathode/segment invariants.
module tb_led_scan_controller;
   logic clk;
   logic rst;

   led_scan_controller_if #(.NUM_DIGITS(4)) bus ();

   led_scan_controller #(
      .NUM_DIGITS  (4),
      .DIGIT_CYCLES(8),
      .BLANK_CYCLES(1)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int unsigned n_vec;
   int unsigned n_err;

   logic [7:0] cur_shown  [4];
   logic [7:0] prev_shown [4];
   logic [3:0] cur_lit;
   logic [3:0] prev_lit;
   int         since;
   int         period;
   int         frames;
   int         lows;
   int         run_len;
   logic [3:0] run_pat;
   logic [6:0] seg;

   assign seg = {bus.seg_g, bus.seg_f, bus.seg_e, bus.seg_d, bus.seg_c, bus.seg_b, bus.seg_a};

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      since = 0; period = 0; frames = 0; run_len = 0; run_pat = 4'hF;
      cur_lit = '0; prev_lit = '0;
      for (int i = 0; i < 4; i++) begin
         cur_shown[i] = '0;
         prev_shown[i] = '0;
      end
   end

   // Invariant checks and per-frame capture, sampled away from the active edge.
   always @(negedge clk) begin
      lows = $countones(~bus.n_digit);
      chk("one_low", 32'(lows <= 1), 32'd1);
      if (lows == 0) chk("dark_seg", {24'd0, bus.dp, seg}, 32'd0);
      if (lows == 1 && bus.n_digit == run_pat) begin
         run_len++;
      end else begin
         if (run_len != 0 && bus.enable && !rst) chk("low_len", run_len, 32'd8);
         run_len = (lows == 1) ? 1 : 0;
         run_pat = bus.n_digit;
      end
      if (lows == 1) begin
         for (int i = 0; i < 4; i++) begin
            if (!bus.n_digit[i]) begin
               cur_shown[i] = {bus.dp, seg};
               cur_lit[i] = 1'b1;
            end
         end
      end
      if (bus.frame_tick) begin
         for (int i = 0; i < 4; i++) begin
            prev_shown[i] = cur_shown[i];
            cur_shown[i] = '0;
         end
         prev_lit = cur_lit;
         cur_lit = '0;
         period = since;
         since = 1;
         frames++;
      end else begin
         since++;
      end
   end

   task automatic cyc();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_tick();
      int start;
      int n;
      start = frames;
      n = 0;
      while (frames == start && n < 200) begin
         cyc();
         n++;
      end
      if (frames == start) chk("tick_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_pat(input logic [3:0] pat);
      int n;
      n = 0;
      while (bus.n_digit != pat && n < 200) begin
         cyc();
         n++;
      end
      if (bus.n_digit != pat) chk("pat_timeout", {28'd0, bus.n_digit}, {28'd0, pat});
   endtask

   task automatic do_load(input logic [15:0] v, input logic [3:0] dpm, input logic [3:0] blk);
      bus.load = 1'b1;
      bus.value = v;
      bus.dp_mask = dpm;
      bus.blank_mask = blk;
      cyc();
      bus.load = 1'b0;
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      rst = 1'b1;
      bus.load = 1'b0;
      bus.value = '0;
      bus.dp_mask = '0;
      bus.blank_mask = '0;
      bus.enable = 1'b1;
      cyc();
      cyc();
      chk("rst_ndigit", {28'd0, bus.n_digit}, 32'hF);
      chk("rst_seg", {24'd0, bus.dp, seg}, 32'h0);
      chk("rst_tick", {31'd0, bus.frame_tick}, 32'd0);
      chk("rst_pending", {31'd0, bus.pending}, 32'd0);
      rst = 1'b0;

      // Basic load and display
      do_load(16'h1234, 4'b0100, 4'b0000);
      chk("load_pending", {31'd0, bus.pending}, 32'd1);
      wait_tick();
      chk("swap_tick", {31'd0, bus.frame_tick}, 32'd1);
      chk("swap_pending", {31'd0, bus.pending}, 32'd0);
      wait_tick();
      chk("d0_is_4", {24'd0, prev_shown[0]}, 32'h66);
      chk("d1_is_3", {24'd0, prev_shown[1]}, 32'h4F);
      chk("d2_is_2dp", {24'd0, prev_shown[2]}, 32'hDB);
      chk("d3_is_1", {24'd0, prev_shown[3]}, 32'h06);
      chk("period", period, 32'd36);

      // Mid-frame load waits for the boundary
      wait_pat(4'b1101);
      do_load(16'h8888, 4'b0000, 4'b0000);
      chk("mid_pending", {31'd0, bus.pending}, 32'd1);
      wait_tick();
      chk("mid_old_d1", {24'd0, prev_shown[1]}, 32'h4F);
      chk("mid_old_d3", {24'd0, prev_shown[3]}, 32'h06);
      chk("mid_swap_pending", {31'd0, bus.pending}, 32'd0);
      wait_tick();
      for (int i = 0; i < 4; i++) chk("all_8", {24'd0, prev_shown[i]}, 32'h7F);

      // Load exactly in the boundary cycle bypasses the pending buffer
      wait_pat(4'b0111);
      repeat (7) cyc();
      do_load(16'hABCD, 4'b0000, 4'b0000);
      chk("bnd_tick", {31'd0, bus.frame_tick}, 32'd1);
      chk("bnd_no_pending", {31'd0, bus.pending}, 32'd0);
      wait_tick();
      chk("bnd_d0_d", {24'd0, prev_shown[0]}, 32'h5E);
      chk("bnd_d1_C", {24'd0, prev_shown[1]}, 32'h39);
      chk("bnd_d2_b", {24'd0, prev_shown[2]}, 32'h7C);
      chk("bnd_d3_A", {24'd0, prev_shown[3]}, 32'h77);

      // Two loads in one frame: last wins
      do_load(16'h1111, 4'b0000, 4'b0000);
      repeat (5) cyc();
      do_load(16'h5678, 4'b0001, 4'b0000);
      chk("two_pending", {31'd0, bus.pending}, 32'd1);
      wait_tick();
      wait_tick();
      chk("two_d0", {24'd0, prev_shown[0]}, 32'hFF);
      chk("two_d1", {24'd0, prev_shown[1]}, 32'h07);
      chk("two_d2", {24'd0, prev_shown[2]}, 32'h7D);
      chk("two_d3", {24'd0, prev_shown[3]}, 32'h6D);

      // Blanked digit keeps its slot
      do_load(16'h0042, 4'b0000, 4'b1000);
      wait_tick();
      wait_tick();
      chk("blk_lit", {28'd0, prev_lit}, 32'h7);
      chk("blk_d0", {24'd0, prev_shown[0]}, 32'h5B);
      chk("blk_d1", {24'd0, prev_shown[1]}, 32'h66);
      chk("blk_d2", {24'd0, prev_shown[2]}, 32'h3F);
      chk("blk_period", period, 32'd36);

      // Enable low mid digit 2, then resume on the same digit
      wait_pat(4'b1011);
      repeat (3) cyc();
      bus.enable = 1'b0;
      cyc();
      chk("off_dark", {28'd0, bus.n_digit}, 32'hF);
      chk("off_seg", {24'd0, bus.dp, seg}, 32'h0);
      do_load(16'h9999, 4'b0000, 4'b0000);
      chk("off_pending", {31'd0, bus.pending}, 32'd1);
      repeat (18) cyc();
      chk("off_still_dark", {28'd0, bus.n_digit}, 32'hF);
      bus.enable = 1'b1;
      cyc();
      chk("resume_blank", {28'd0, bus.n_digit}, 32'hF);
      for (int i = 0; i < 8; i++) begin
         cyc();
         chk("resume_d2", {28'd0, bus.n_digit}, 32'hB);
      end
      chk("resume_seg", {25'd0, seg}, 32'h3F);
      cyc();
      chk("resume_gap", {28'd0, bus.n_digit}, 32'hF);

      // Reset during digit 3 drive
      wait_tick();
      wait_pat(4'b0111);
      cyc();
      do_load(16'h3333, 4'b0000, 4'b0000);
      chk("pre_rst_pending", {31'd0, bus.pending}, 32'd1);
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      chk("rst2_ndigit", {28'd0, bus.n_digit}, 32'hF);
      chk("rst2_seg", {24'd0, bus.dp, seg}, 32'h0);
      chk("rst2_pending", {31'd0, bus.pending}, 32'd0);
      wait_tick();
      wait_tick();
      chk("rst2_stays_dark", {28'd0, prev_lit}, 32'h0);
      do_load(16'h0005, 4'b0000, 4'b0000);
      wait_tick();
      wait_tick();
      chk("rst2_relit", {28'd0, prev_lit}, 32'hF);
      chk("rst2_d0", {24'd0, prev_shown[0]}, 32'h6D);
      chk("rst2_d1", {24'd0, prev_shown[1]}, 32'h3F);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
